// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte requesters.
// Times each frame locally because the UART exposes no busy flag.
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FRAME_BITS   = 10,
  parameter int unsigned GAP_CYCLES   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        tx_send,
  output logic [7:0]  tx_data,
  output logic [1:0]  grant_id,
  output logic        busy
);

  localparam int unsigned FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS + GAP_CYCLES;
  localparam int unsigned CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         last_grant_q, last_grant_d;
  logic               tx_send_q, tx_send_d;
  logic [3:0]         req_ready_q, req_ready_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [1:0]         grant_id_q, grant_id_d;
  logic               busy_q, busy_d;

  logic               win_found;
  logic [1:0]         win_idx;
  logic [1:0]         cand;

  // Scan from last_grant+1 upward; i=4 wraps back onto last_grant itself.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_grant_q + i[1:0];
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    tx_send_d    = 1'b0;
    req_ready_d  = '0;
    tx_data_d    = tx_data_q;
    grant_id_d   = grant_id_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d      = ST_SEND;
          tx_send_d    = 1'b1;
          req_ready_d  = 4'b0001 << win_idx;
          tx_data_d    = req_data[{win_idx, 3'b000} +: 8];
          grant_id_d   = win_idx;
          last_grant_d = win_idx;
        end
      end
      ST_SEND: begin
        cnt_d   = CNT_W'(FRAME_CYCLES - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 2'd3;
      tx_send_q    <= 1'b0;
      req_ready_q  <= '0;
      tx_data_q    <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      tx_send_q    <= tx_send_d;
      req_ready_q  <= req_ready_d;
      tx_data_q    <= tx_data_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
    end
  end

  assign tx_send   = tx_send_q;
  assign req_ready = req_ready_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic
// against a frame-timer reference model.
module tb_uart_tx_arbiter;

  localparam int unsigned CPB = 4;
  localparam int unsigned FB  = 10;
  localparam int unsigned GAP = 0;
  localparam int          FC  = CPB * FB + GAP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        busy;

  uart_tx_arbiter #(
    .CLKS_PER_BIT (CPB),
    .FRAME_BITS   (FB),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: remaining non-idle cycles after a grant, plus last winner.
  int         m_last;
  int         m_left;
  logic       m_send;
  logic [3:0] m_ready;
  logic [7:0] m_data;
  logic [1:0] m_grant;

  int  cyc = 0;
  bit  auto_drop = 1'b1;

  function automatic int rr_pick(int last, logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_last  = 3;
    m_left  = 0;
    m_send  = 1'b0;
    m_ready = '0;
    m_data  = '0;
    m_grant = '0;
  endtask

  task automatic model_step();
    int g;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_send  = 1'b0;
    m_ready = '0;
    if (m_left == 0) begin
      g = rr_pick(m_last, req_valid);
      if (g >= 0) begin
        m_last  = g;
        m_grant = 2'(g);
        m_data  = req_data[g*8 +: 8];
        m_send  = 1'b1;
        m_ready = 4'(1 << g);
        m_left  = FC + 1;
      end
    end else begin
      m_left--;
    end
  endtask

  task automatic check_all();
    check("tx_send",   32'(tx_send),   32'(m_send));
    check("req_ready", 32'(req_ready), 32'(m_ready));
    check("tx_data",   32'(tx_data),   32'(m_data));
    check("grant_id",  32'(grant_id),  32'(m_grant));
    check("busy",      32'(busy),      32'(m_left != 0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check_all();
    if (auto_drop) req_valid = req_valid & ~req_ready;
  endtask

  int busy_cnt;
  int s1;
  int s3;
  int last_send;
  int ready1_cnt;
  logic [1:0] g_q[$];
  logic [7:0] d_q[$];
  logic [1:0] exp_order[5];
  logic [7:0] exp_bytes[5];

  initial begin
    model_reset();

    // Reset: held 3 cycles, then 10 idle cycles
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();

    // Single request from requester 2
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    tick();
    check("single_send",  32'(tx_send),   32'd1);
    check("single_ready", 32'(req_ready), 32'b0100);
    check("single_data",  32'(tx_data),   32'hA5);
    check("single_grant", 32'(grant_id),  32'd2);
    busy_cnt = 1;
    repeat (45) begin
      tick();
      if (busy) busy_cnt++;
    end
    check("single_busy_len", 32'(busy_cnt), 32'd41);

    // All four requesting continuously, from reset priority
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk) rst_n = 1'b1;
    auto_drop = 1'b0;
    req_data  = 32'h13121110;
    req_valid = 4'b1111;
    last_send = -1;
    repeat (175) begin
      tick();
      if (tx_send) begin
        g_q.push_back(grant_id);
        d_q.push_back(tx_data);
        if (last_send >= 0) check("rr_spacing", 32'(cyc - last_send), 32'd42);
        last_send = cyc;
      end
    end
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    check("rr_count", 32'(g_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < g_q.size()) begin
        check("rr_order", 32'(g_q[i]), 32'(exp_order[i]));
        check("rr_bytes", 32'(d_q[i]), 32'(exp_bytes[i]));
      end
    end
    req_valid = '0;
    auto_drop = 1'b1;
    repeat (45) tick();

    // Mid-frame request from requester 3 during a requester-1 frame
    req_data[15:8] = 8'h21;
    req_valid = 4'b0010;
    tick();
    s1 = cyc;
    check("mid_grant1", 32'(grant_id), 32'd1);
    tick();
    repeat (5) tick();
    req_data[31:24] = 8'h3C;
    req_valid[3] = 1'b1;
    s3 = 0;
    for (int i = 0; i < 60 && s3 == 0; i++) begin
      tick();
      if (tx_send) s3 = cyc;
    end
    check("mid_spacing", 32'(s3 - s1), 32'd42);
    check("mid_grant3",  32'(grant_id), 32'd3);
    check("mid_data3",   32'(tx_data),  32'h3C);

    // Withdrawal: requester 1 pulses valid for one cycle during WAIT
    repeat (10) tick();
    req_valid[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    ready1_cnt = 0;
    repeat (50) begin
      tick();
      if (req_ready[1]) ready1_cnt++;
    end
    check("withdraw_no_grant", 32'(ready1_cnt), 32'd0);
    check("withdraw_idle",     32'(busy),       32'd0);

    // Reset mid-operation at WAIT count 20
    req_data[7:0] = 8'h5A;
    req_valid = 4'b0001;
    tick();
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    check("rst_busy_clear", 32'(busy), 32'd0);
    req_valid = 4'b1000;
    req_data[31:24] = 8'hC3;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_grant3", 32'(grant_id), 32'd3);
    check("rst_send",   32'(tx_send),  32'd1);
    repeat (45) tick();
    req_valid = 4'b0011;
    tick();
    check("rst_next_is_0", 32'(grant_id), 32'd0);
    repeat (45) tick();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      for (int r = 0; r < 4; r++) begin
        if (!req_valid[r]) begin
          req_data[r*8 +: 8] = 8'($urandom);
          if ($urandom_range(7, 0) == 0) req_valid[r] = 1'b1;
        end else if ($urandom_range(63, 0) == 0) begin
          req_valid[r] = 1'b0;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter between four byte-producing requesters (debug counters, status reporters, etc.). It drives the UART's one-cycle `transmit` strobe and `data` byte. Because the UART exposes no busy flag, the block times each frame itself and holds off further strobes until the frame has left the line. It sits between the requesters and the `uart` instance in the top level, replacing the free-running send counter.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit; 50 MHz / 115200 baud.
- FRAME_BITS, 10, bits per frame: start + 8 data + stop.
- GAP_CYCLES, 0, extra idle cycles appended after each frame.
- Derived, not overridable: FRAME_CYCLES = CLKS_PER_BIT*FRAME_BITS + GAP_CYCLES.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset: asynchronous, active-low.
- req_valid  in  4  per-requester byte pending; bit i belongs to requester i.
- req_data  in  32  packed bytes; requester i uses [8i+7:8i].
- req_ready  out  4  one-hot, one-cycle acceptance pulse.
- tx_send  out  1  one-cycle strobe to the UART `transmit` input.
- tx_data  out  8  byte to the UART `data` input; held stable between grants.
- grant_id  out  2  index of the last granted requester.
- busy  out  1  high while a frame is being strobed or is in flight.

## Operation
- The state machine has three states: IDLE, SEND and WAIT.
- **IDLE:** if any req_valid bit is high at a clk edge:
  - Select the winner g by round-robin, starting from last_grant+1 and wrapping 3→0.
  - Load tx_data ← req_data[8g+7:8g], grant_id ← g, last_grant ← g.
  - Go to SEND.
  - If no bit is high, stay in IDLE.
- **SEND:** lasts exactly 1 cycle.
  - tx_send=1 and req_ready[g]=1.
  - Load the frame counter with FRAME_CYCLES-1.
  - Go to WAIT.
  - req_valid is ignored in this state.
- **WAIT:** the counter decrements each cycle.
  - When it reads 0, go to IDLE.
  - WAIT lasts FRAME_CYCLES cycles.
  - req_valid is ignored in this state.
- **Registered outputs:** all outputs are registered. busy = (state != IDLE).
- **Requester rules:**
  - Hold valid and data stable until req_ready.
  - Data is captured on the IDLE→SEND edge, so changing data during SEND has no effect on the byte sent.
  - Dropping valid before a grant withdraws the request with no side effects.
- **Fairness:** a requester that holds valid continuously is served at least once every 4 grants.
- **Widths:** the frame counter is $clog2(FRAME_CYCLES) bits wide and never underflows. The round-robin pointer wraps modulo 4.

## Timing
- **Reset values:** state=IDLE, last_grant=3 (requester 0 has first priority), tx_send=0, req_ready=0, tx_data=8'h00, grant_id=0, busy=0, counter=0.
- **Reset mid-operation:** outputs return to reset values immediately (asynchronous).
  - Any frame in flight is abandoned.
  - The interrupted requester receives no further req_ready for that byte.
- **Latency:** req_valid high in IDLE at edge N → tx_send and req_ready at cycle N+1.
- **Spacing:** minimum spacing between tx_send pulses is FRAME_CYCLES+2 cycles (SEND + WAIT + one IDLE arbitration cycle).
- **Simultaneous requests:** exactly one grant per IDLE cycle, chosen by round-robin order.
- **New requests during SEND/WAIT:** requests arriving in these states queue implicitly. They are arbitrated on the first IDLE cycle.
- **req_ready:** exactly one bit is high per SEND cycle, never in other states. It is always coincident with tx_send.
- **tx_data:** changes only on the IDLE→SEND edge.

## Test plan
Bench parameters: CLKS_PER_BIT=4, FRAME_BITS=10, GAP_CYCLES=0, so FRAME_CYCLES=40.

- **Reset check:**
  - Stimulus: assert rst_n=0 for 3 cycles, then release.
  - Required response: all outputs are 0, and busy=0 for 10 idle cycles.
- **Single request:**
  - Stimulus: req_valid=4'b0100, req_data[23:16]=8'hA5 at edge N.
  - Required response:
    - tx_send=1, req_ready=4'b0100, tx_data=8'hA5, grant_id=2 at N+1.
    - busy high for 41 cycles, then low.
- **All four requesting continuously** (bytes 8'h10, 8'h11, 8'h12, 8'h13):
  - Grant order is 0,1,2,3,0, and tx_data follows.
  - tx_send pulses are exactly 42 cycles apart.
- **Mid-frame request:**
  - Stimulus: requester 3 raises valid 5 cycles into WAIT of a requester-1 frame.
  - Required response:
    - Requester 3 is granted on the cycle after WAIT ends.
    - No tx_send during WAIT.
- **Withdrawal:**
  - Stimulus: requester 1 pulses valid for 1 cycle during WAIT, then drops it.
  - Required response: no grant to 1, and the block stays IDLE afterwards.
- **Reset mid-operation:**
  - Stimulus: assert rst_n=0 at WAIT count 20, then release with req_valid=4'b1000.
  - Required response:
    - Outputs clear immediately.
    - After release, requester 3 is granted 1 cycle later, and last_grant is then 3.
